imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 24 ++
 rtl/imem_loader.sv | 119 +++++++++++
 tb/tb_imem_loader.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding and
// default sizing used when the loader is instantiated without overrides.
package imem_loader_pkg;

  // Loader phases: accept the first word, accept more words, hold the core
  // in reset for a short settle time, let the core run, or stop on overflow.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RELEASE = 3'd2,
    ST_RUN     = 3'd3,
    ST_ERROR   = 3'd4
  } state_t;

  localparam int          DEFAULT_DEPTH_WORDS    = 1024;
  localparam int          DEFAULT_RELEASE_CYCLES = 4;
  localparam logic [31:0] DEFAULT_BASE_ADDR      = 32'h0000_0000;

  // The source may only hand over words while the loader is still filling memory.
  function automatic logic accepts_words(input state_t s);
    return (s == ST_IDLE) || (s == ST_LOAD);
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Streams a program into instruction memory one 32-bit word per transfer,
// then holds the core in reset for RELEASE_CYCLES before letting it run.
// Writing past DEPTH_WORDS parks the loader in a sticky error state with the
// core still held in reset. RELEASE_CYCLES must lie in 1..255 because the
// settle time is kept in an 8-bit down-counter.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          DEPTH_WORDS    = DEFAULT_DEPTH_WORDS,
  parameter logic [31:0] BASE_ADDR      = DEFAULT_BASE_ADDR,
  parameter int          RELEASE_CYCLES = DEFAULT_RELEASE_CYCLES
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic [31:0]                    in_data,
  input  logic                           in_last,
  output logic                           in_ready,
  output logic                           imem_we,
  output logic [31:0]                    imem_addr,
  output logic [31:0]                    imem_wdata,
  output logic                           core_rst,
  output logic                           done,
  output logic                           err,
  output logic [$clog2(DEPTH_WORDS):0]   word_count
);

  localparam int             CW       = $clog2(DEPTH_WORDS) + 1;
  localparam logic [CW-1:0]  FULL     = CW'(DEPTH_WORDS);
  localparam logic [7:0]     REL_LOAD = 8'(RELEASE_CYCLES);

  state_t     state;
  state_t     next_state;
  logic [7:0] rel_cnt;
  logic [7:0] rel_cnt_next;
  logic       transfer;
  logic       full;
  logic       write_ok;

  // A word is handed over only when offered and accepted in the same cycle;
  // once memory is full a further word is swallowed without being written.
  assign transfer = in_valid && in_ready;
  assign full     = (word_count == FULL);
  assign write_ok = transfer && !full;

  // The core sees reset released and the loader reports done only while running.
  assign core_rst = (state == ST_RUN);
  assign done     = (state == ST_RUN);

  // Next-state and release-counter logic; everything defaults to holding.
  always_comb begin
    next_state   = state;
    rel_cnt_next = rel_cnt;
    case (state)
      ST_IDLE, ST_LOAD: begin
        if (transfer) begin
          if (full) begin
            next_state = ST_ERROR;
          end else if (in_last) begin
            next_state   = ST_RELEASE;
            rel_cnt_next = REL_LOAD;
          end else begin
            next_state = ST_LOAD;
          end
        end
      end
      ST_RELEASE: begin
        if (rel_cnt <= 8'd1) begin
          next_state   = ST_RUN;
          rel_cnt_next = 8'd0;
        end else begin
          rel_cnt_next = rel_cnt - 8'd1;
        end
      end
      ST_RUN, ST_ERROR: begin
        next_state = state;
      end
      default: begin
        next_state   = ST_IDLE;
        rel_cnt_next = 8'd0;
      end
    endcase
  end

  // State, release counter, handshake and error flag; ready is registered from
  // the next state so it rises on the first edge after reset is released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      rel_cnt  <= 8'd0;
      in_ready <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= next_state;
      rel_cnt  <= rel_cnt_next;
      in_ready <= accepts_words(next_state);
      err      <= err || (transfer && full);
    end
  end

  // Registered memory write port: each accepted word appears exactly one cycle
  // later at the next word-aligned address, and the word count advances.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= 32'd0;
      word_count <= '0;
    end else begin
      imem_we <= write_ok;
      if (write_ok) begin
        imem_addr  <= BASE_ADDR + (32'(word_count) << 2);
        imem_wdata <= in_data;
        word_count <= word_count + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected writes into a
// queue, a negedge monitor pops and compares every write strobe it sees.
module tb_imem_loader;

  localparam int DEPTH = 4;
  localparam int REL   = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [31:0]   in_data;
  logic          in_last;
  logic          in_ready;
  logic          imem_we;
  logic [31:0]   imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rst;
  logic          done;
  logic          err;
  logic [CW-1:0] word_count;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t exp_q[$];
  int  vectors     = 0;
  int  miscompares = 0;
  int  cyc         = 0;
  int  m_count     = 0;
  bit  m_ready     = 1'b0;

  imem_loader #(
    .DEPTH_WORDS    (DEPTH),
    .BASE_ADDR      (32'h0000_0000),
    .RELEASE_CYCLES (REL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst   (core_rst),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  // Free-running clock and cycle counter used to pin write latency.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write, including its cycle.
  always @(negedge clk) begin
    if (rst === 1'b1 && imem_we === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_write: got addr=%h data=%h at cycle %0d, expected no write",
                 imem_addr, imem_wdata, cyc);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (imem_addr !== e.addr || imem_wdata !== e.data || cyc != e.cyc) begin
          miscompares++;
          $display("[TB] FAIL write: got addr=%h data=%h cycle %0d, expected addr=%h data=%h cycle %0d",
                   imem_addr, imem_wdata, cyc, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  // Offer one word for one cycle; the model decides whether it is accepted/written.
  task automatic apply_stimulus(input logic [31:0] d, input logic last);
    bit acc;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge clk);
    check_output("in_ready_offer", 32'(in_ready), 32'(m_ready));
    acc = m_ready;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    in_last  = 1'($urandom);
    if (acc) begin
      if (m_count == DEPTH) begin
        m_ready = 1'b0;
      end else begin
        exp_q.push_back('{addr: 32'(m_count * 4), data: d, cyc: cyc});
        m_count++;
        if (last) m_ready = 1'b0;
      end
    end
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    in_data  = $urandom;
    in_last  = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // After the last word: REL cycles with core held, then running.
  task automatic check_release(input logic [CW-1:0] exp_count);
    for (int i = 0; i < REL; i++) begin
      @(negedge clk);
      check_output("core_rst_held", 32'(core_rst), 32'd0);
      check_output("done_low_release", 32'(done), 32'd0);
    end
    @(negedge clk);
    check_output("core_rst_released", 32'(core_rst), 32'd1);
    check_output("done_run", 32'(done), 32'd1);
    check_output("in_ready_run", 32'(in_ready), 32'd0);
    check_output("word_count_run", 32'(word_count), 32'(exp_count));
    check_output("err_run", 32'(err), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2;
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check_output("rst_in_ready", 32'(in_ready), 32'd0);
    check_output("rst_imem_we", 32'(imem_we), 32'd0);
    check_output("rst_imem_addr", imem_addr, 32'h0);
    check_output("rst_imem_wdata", imem_wdata, 32'h0);
    check_output("rst_core_rst", 32'(core_rst), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_err", 32'(err), 32'd0);
    check_output("rst_word_count", 32'(word_count), 32'd0);
    m_count = 0;
    m_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    @(negedge clk);
    check_output("ready_before_first_edge", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    check_output("ready_after_first_edge", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = 32'h0;
    in_last  = 1'b0;
    do_reset();

    // Three-word program, last word flagged.
    apply_stimulus(32'h0050_0293, 1'b0);
    apply_stimulus(32'h0030_0313, 1'b0);
    apply_stimulus(32'h0062_83B3, 1'b1);
    check_release(3'd3);

    // Single word with last straight from IDLE, then a word offered in RUN.
    do_reset();
    apply_stimulus(32'hDEAD_BEEF, 1'b1);
    check_release(3'd1);
    apply_stimulus(32'h1234_5678, 1'b0);
    @(negedge clk);
    check_output("done_stays_run", 32'(done), 32'd1);
    check_output("word_count_after_run_offer", 32'(word_count), 32'd1);
    @(posedge clk);
    #1;

    // Valid toggled 1-0-1: no write in the gap, addresses stay contiguous.
    do_reset();
    apply_stimulus(32'hA5A5_0001, 1'b0);
    idle_cycle();
    apply_stimulus(32'hA5A5_0002, 1'b1);
    check_release(3'd2);

    // Last word exactly fills memory: legal.
    do_reset();
    apply_stimulus(32'h0000_1111, 1'b0);
    apply_stimulus(32'h0000_2222, 1'b0);
    apply_stimulus(32'h0000_3333, 1'b0);
    apply_stimulus(32'h0000_4444, 1'b1);
    check_release(3'd4);

    // Overflow: five words without last into a four-word memory.
    do_reset();
    for (int i = 0; i < 5; i++) apply_stimulus(32'hC000_0000 + 32'(i), 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_output("err_sticky", 32'(err), 32'd1);
      check_output("core_rst_err", 32'(core_rst), 32'd0);
      check_output("in_ready_err", 32'(in_ready), 32'd0);
      check_output("word_count_err", 32'(word_count), 32'd4);
    end
    @(posedge clk);
    #1;

    // Reset in the middle of a load aborts it; the next load restarts at 0x0.
    do_reset();
    apply_stimulus(32'hB000_0001, 1'b0);
    apply_stimulus(32'hB000_0002, 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'hB000_0003;
    in_last  = 1'b0;
    do_reset();
    apply_stimulus(32'hE000_0001, 1'b1);
    check_release(3'd1);

    @(negedge clk);
    check_output("pending_writes", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
